// File: rtl/tl_phase_ctrl.sv
// Two-road traffic-light phase controller: sequences NS/EW lamp phases on timebase
// ticks, serves side-road and pedestrian demand, and supports flashing-yellow mode.
module tl_phase_ctrl #(
    parameter int T_NSG   = 20,
    parameter int T_EWG   = 15,
    parameter int T_Y     = 3,
    parameter int T_AR    = 1,
    parameter int T_MIN_G = 5,
    parameter int CW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          ew_req,
    input  logic          ped_req,
    input  logic          flash,
    output logic [2:0]    ns_light,
    output logic [2:0]    ew_light,
    output logic          walk,
    output logic [CW-1:0] remain,
    output logic [2:0]    state
);

    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        AR1   = 3'd2,
        EW_G  = 3'd3,
        EW_Y  = 3'd4,
        AR2   = 3'd5,
        FLASH = 3'd6
    } phase_t;

    localparam logic [CW-1:0] R_NSG  = CW'(T_NSG);
    localparam logic [CW-1:0] R_EWG  = CW'(T_EWG);
    localparam logic [CW-1:0] R_Y    = CW'(T_Y);
    localparam logic [CW-1:0] R_AR   = CW'(T_AR);
    localparam logic [CW-1:0] R_MING = CW'(T_MIN_G);
    localparam logic [CW-1:0] R_ONE  = CW'(1);

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;

    phase_t        state_q, state_d;
    logic [CW-1:0] remain_q, remain_d;
    logic          fph_q, fph_d;
    logic          req_l_q, req_l_d;
    logic          ped_l_q, ped_l_d;
    logic          walk_q, walk_d;
    logic [2:0]    ns_q, ns_d;
    logic [2:0]    ew_q, ew_d;

    logic req_nxt, ped_nxt, enter_ew;

    always_comb begin
        // Requests arriving in the deciding clock are honoured, so decisions use
        // the would-be latch value rather than the registered one.
        req_nxt  = req_l_q | ew_req;
        ped_nxt  = ped_l_q | ped_req;
        state_d  = state_q;
        remain_d = remain_q;
        fph_d    = fph_q;

        if (!(state_q inside {NS_G, NS_Y, AR1, EW_G, EW_Y, AR2, FLASH})) begin
            state_d  = AR2;
            remain_d = R_AR;
        end else if (tick) begin
            if (flash && state_q != FLASH) begin
                state_d  = FLASH;
                fph_d    = 1'b1;
                remain_d = '0;
            end else if (state_q == FLASH) begin
                if (flash) begin
                    fph_d = ~fph_q;
                end else begin
                    state_d  = AR2;
                    remain_d = R_AR;
                    fph_d    = 1'b0;
                end
            end else if (state_q == NS_G && ped_nxt && remain_q > R_MING) begin
                remain_d = R_MING;
            end else if (remain_q > R_ONE) begin
                remain_d = remain_q - R_ONE;
            end else begin
                case (state_q)
                    NS_G: begin
                        if (req_nxt || ped_nxt) begin
                            state_d  = NS_Y;
                            remain_d = R_Y;
                        end else begin
                            remain_d = R_NSG;
                        end
                    end
                    NS_Y:    begin state_d = AR1;  remain_d = R_AR;  end
                    AR1:     begin state_d = EW_G; remain_d = R_EWG; end
                    EW_G:    begin state_d = EW_Y; remain_d = R_Y;   end
                    EW_Y:    begin state_d = AR2;  remain_d = R_AR;  end
                    default: begin state_d = NS_G; remain_d = R_NSG; end
                endcase
            end
        end

        enter_ew = (state_d == EW_G) && (state_q != EW_G);
        req_l_d  = enter_ew ? 1'b0 : req_nxt;
        ped_l_d  = enter_ew ? 1'b0 : ped_nxt;

        if (state_d == EW_G) begin
            walk_d = enter_ew ? ped_nxt : walk_q;
        end else begin
            walk_d = 1'b0;
        end

        case (state_d)
            NS_G:    begin ns_d = L_GRN; ew_d = L_RED; end
            NS_Y:    begin ns_d = L_YEL; ew_d = L_RED; end
            EW_G:    begin ns_d = L_RED; ew_d = L_GRN; end
            EW_Y:    begin ns_d = L_RED; ew_d = L_YEL; end
            FLASH:   begin ns_d = {1'b0, fph_d, 1'b0}; ew_d = {1'b0, fph_d, 1'b0}; end
            default: begin ns_d = L_RED; ew_d = L_RED; end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= AR2;
            remain_q <= R_AR;
            fph_q    <= 1'b0;
            req_l_q  <= 1'b0;
            ped_l_q  <= 1'b0;
            walk_q   <= 1'b0;
            ns_q     <= L_RED;
            ew_q     <= L_RED;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            fph_q    <= fph_d;
            req_l_q  <= req_l_d;
            ped_l_q  <= ped_l_d;
            walk_q   <= walk_d;
            ns_q     <= ns_d;
            ew_q     <= ew_d;
        end
    end

    assign state    = state_q;
    assign remain   = remain_q;
    assign walk     = walk_q;
    assign ns_light = ns_q;
    assign ew_light = ew_q;

endmodule

// File: tb/tb_tl_phase_ctrl.sv
// Directed bench for tl_phase_ctrl with short phase durations and hand-computed expectations.
module tb_tl_phase_ctrl;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       ew_req;
    logic       ped_req;
    logic       flash;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic [7:0] remain;
    logic [2:0] state;

    int n_chk  = 0;
    int n_pass = 0;

    tl_phase_ctrl #(
        .T_NSG(6), .T_EWG(4), .T_Y(2), .T_AR(1), .T_MIN_G(2), .CW(8)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .ew_req(ew_req), .ped_req(ped_req),
        .flash(flash), .ns_light(ns_light), .ew_light(ew_light), .walk(walk),
        .remain(remain), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            @(posedge clk);
            #1;
            tick = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ew;
        ew_req = 1'b1;
        idle(1);
        ew_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; ew_req = 1'b0; ped_req = 1'b0; flash = 1'b0;
        #2;
        chk("rst_state", state, 5);
        chk("rst_remain", remain, 1);
        chk("rst_ns", ns_light, 3'b100);
        chk("rst_ew", ew_light, 3'b100);
        chk("rst_walk", walk, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // rest on main road
        ticks(1);
        chk("t1_state", state, 0);
        chk("t1_remain", remain, 6);
        ticks(6);
        chk("rest_state", state, 0);
        chk("rest_remain", remain, 6);
        chk("rest_ns", ns_light, 3'b001);
        chk("rest_ew", ew_light, 3'b100);

        // vehicle request full cycle
        pulse_ew();
        ticks(6);
        chk("veh_nsy", state, 1);
        chk("veh_nsy_rem", remain, 2);
        chk("veh_nsy_ns", ns_light, 3'b010);
        ticks(2);
        chk("veh_ar1", state, 2);
        chk("veh_ar1_rem", remain, 1);
        ticks(1);
        chk("veh_ewg", state, 3);
        chk("veh_ewg_rem", remain, 4);
        chk("veh_ewg_walk", walk, 0);
        chk("veh_ewg_ew", ew_light, 3'b001);
        ticks(4);
        chk("veh_ewy", state, 4);
        chk("veh_ewy_ew", ew_light, 3'b010);
        ticks(2);
        chk("veh_ar2", state, 5);
        ticks(1);
        chk("veh_nsg", state, 0);
        chk("veh_nsg_rem", remain, 6);

        // pedestrian truncation and walk
        ticks(1);
        chk("ped_pre_rem", remain, 5);
        ped_req = 1'b1;
        idle(1);
        ped_req = 1'b0;
        ticks(1);
        chk("ped_trunc_rem", remain, 2);
        ticks(2);
        chk("ped_nsy", state, 1);
        ticks(3);
        chk("ped_ewg", state, 3);
        chk("ped_walk_on", walk, 1);
        ticks(4);
        chk("ped_ewy", state, 4);
        chk("ped_walk_off", walk, 0);
        ticks(3);
        chk("ped_back_nsg", state, 0);

        // request in the very clock of the ending tick
        ticks(5);
        chk("late_pre_rem", remain, 1);
        tick = 1'b1; ew_req = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0; ew_req = 1'b0;
        chk("late_state", state, 1);
        chk("late_rem", remain, 2);

        // flash mode
        ticks(3);
        chk("fl_ewg", state, 3);
        ticks(1);
        chk("fl_ewg_rem", remain, 3);
        flash = 1'b1;
        idle(5);
        chk("fl_hold_state", state, 3);
        chk("fl_hold_rem", remain, 3);
        ticks(1);
        chk("fl_state", state, 6);
        chk("fl_ns_on", ns_light, 3'b010);
        chk("fl_ew_on", ew_light, 3'b010);
        chk("fl_walk", walk, 0);
        ticks(1);
        chk("fl_ns_off", ns_light, 3'b000);
        chk("fl_ew_off", ew_light, 3'b000);
        flash = 1'b0;
        ticks(1);
        chk("fl_exit_state", state, 5);
        chk("fl_exit_rem", remain, 1);
        chk("fl_exit_ns", ns_light, 3'b100);
        chk("fl_exit_ew", ew_light, 3'b100);

        // async reset mid EW_Y clears latches
        ticks(1);
        pulse_ew();
        ticks(9);
        ticks(4);
        chk("ar_pre_state", state, 4);
        ew_req = 1'b1; ped_req = 1'b1;
        idle(1);
        ew_req = 1'b0; ped_req = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("ar_state", state, 5);
        chk("ar_remain", remain, 1);
        chk("ar_ns", ns_light, 3'b100);
        chk("ar_ew", ew_light, 3'b100);
        chk("ar_walk", walk, 0);
        #1;
        rst = 1'b0;
        ticks(1);
        chk("ar_nsg", state, 0);
        ticks(6);
        chk("ar_no_req_state", state, 0);
        chk("ar_no_req_rem", remain, 6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
